fifo_rptr_empty: RTL and testbench

Read-domain pointer and status controller for the asynchronous FIFO. It consumes the write pointer after it has been Gray-coded and synchronized into rclk (two flops, rq2_wptr). It maintains the binary read address and Gray read pointer, and generates a registered empty flag, an almost-empty flag, a fill level and a sticky underflow flag. The rptr output is sent to the read-to-write synchronizer. The raddr output drives the dual-port memory read address.

---
 rtl/fifo_rptr_empty.sv | 93 +++++++++
 tb/tb_fifo_rptr_empty.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_rptr_empty.sv
// Read-side pointer/status block of the async FIFO: binary/Gray read pointer, empty, underflow.
// Define RPTR_LEVEL_EN to build the fill-level (rlevel) and almost-empty threshold logic.
module fifo_rptr_empty #(
    parameter int ADDRSIZE      = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic                rundf_clr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                rundf
);

    logic [ADDRSIZE:0] rbin_reg;
    logic [ADDRSIZE:0] rbin_next;
    logic [ADDRSIZE:0] rgray_next;
    logic [ADDRSIZE:0] rptr_reg;
    logic              rempty_reg;
    logic              rempty_next;
    logic              raempty_reg;
    logic              raempty_next;
    logic              rundf_reg;
    logic              rundf_next;
    logic              rd_ok;

    assign rd_ok       = rinc & ~rempty_reg;
    assign rbin_next   = rbin_reg + {{ADDRSIZE{1'b0}}, rd_ok};
    assign rgray_next  = (rbin_next >> 1) ^ rbin_next;
    // Full-width compare: the MSB distinguishes empty from full.
    assign rempty_next = (rgray_next == rq2_wptr);
    // A refused read sets the flag; set takes priority over clear.
    assign rundf_next  = (rinc & rempty_reg) | (rundf_reg & ~rundf_clr);

`ifdef RPTR_LEVEL_EN
    localparam logic [ADDRSIZE:0] AEMPTY_LIM = (ADDRSIZE+1)'(AEMPTY_THRESH);

    logic [ADDRSIZE:0] wbin_s;
    logic [ADDRSIZE:0] level_next;
    logic [ADDRSIZE:0] rlevel_reg;

    generate
        for (genvar gi = 0; gi <= ADDRSIZE; gi++) begin : g_gray2bin
            assign wbin_s[gi] = ^rq2_wptr[ADDRSIZE:gi];
        end
    endgenerate

    // Synchronized write pointer lags, so this level can only under-report.
    assign level_next   = wbin_s - rbin_next;
    assign raempty_next = (level_next <= AEMPTY_LIM);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rlevel_reg <= '0;
        end else begin
            rlevel_reg <= level_next;
        end
    end

    assign rlevel = rlevel_reg;
`else
    assign raempty_next = rempty_next;
    assign rlevel       = '0;
`endif

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_reg    <= '0;
            rptr_reg    <= '0;
            rempty_reg  <= 1'b1;
            raempty_reg <= 1'b1;
            rundf_reg   <= 1'b0;
        end else begin
            rbin_reg    <= rbin_next;
            rptr_reg    <= rgray_next;
            rempty_reg  <= rempty_next;
            raempty_reg <= raempty_next;
            rundf_reg   <= rundf_next;
        end
    end

    assign raddr   = rbin_reg[ADDRSIZE-1:0];
    assign rptr    = rptr_reg;
    assign rempty  = rempty_reg;
    assign raempty = raempty_reg;
    assign rundf   = rundf_reg;

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Self-checking bench for fifo_rptr_empty: directed and random reads against a count-based model.
module tb_fifo_rptr_empty;

    localparam int ADDRSIZE      = 4;
    localparam int AEMPTY_THRESH = 2;

    logic                rclk;
    logic                rrst_n;
    logic                rinc;
    logic [ADDRSIZE:0]   rq2_wptr;
    logic                rundf_clr;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic                rempty;
    logic                raempty;
    logic [ADDRSIZE:0]   rlevel;
    logic                rundf;

    fifo_rptr_empty #(
        .ADDRSIZE      (ADDRSIZE),
        .AEMPTY_THRESH (AEMPTY_THRESH)
    ) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rinc      (rinc),
        .rq2_wptr  (rq2_wptr),
        .rundf_clr (rundf_clr),
        .raddr     (raddr),
        .rptr      (rptr),
        .rempty    (rempty),
        .raempty   (raempty),
        .rlevel    (rlevel),
        .rundf     (rundf)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // Model: total words written/read as plain integers; level is their difference.
    int m_wr;
    int m_rd;
    bit m_empty;
    bit m_aempty;
    int m_level;
    bit m_undf;
    int n_vec;
    int n_err;

    function automatic logic [ADDRSIZE:0] gray(input int v);
        logic [ADDRSIZE:0] b;
        b = v[ADDRSIZE:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] rd_mod;
        rd_mod = m_rd % (1 << ADDRSIZE);
        $display("[%0t] %s rinc=%0b wr=%0d rd=%0d rempty=%0b raempty=%0b rlevel=%0d rptr=%b raddr=%0d rundf=%0b",
                 $time, tag, rinc, m_wr, m_rd, rempty, raempty, rlevel, rptr, raddr, rundf);
        chk({tag, ".rempty"},  32'(rempty),  32'(m_empty));
        chk({tag, ".raempty"}, 32'(raempty), 32'(m_aempty));
        chk({tag, ".rlevel"},  32'(rlevel),  32'(m_level));
        chk({tag, ".rptr"},    32'(rptr),    32'(gray(m_rd)));
        chk({tag, ".raddr"},   32'(raddr),   rd_mod);
        chk({tag, ".rundf"},   32'(rundf),   32'(m_undf));
    endtask

    task automatic model_reset();
        m_rd     = 0;
        m_empty  = 1'b1;
        m_aempty = 1'b1;
        m_level  = 0;
        m_undf   = 1'b0;
    endtask

    // One clock: drive at negedge, model the edge, sample 1 time unit after posedge.
    task automatic step(input bit inc, input bit clr, input string tag);
        bit accept;
        int lvl;
        @(negedge rclk);
        rinc      = inc;
        rundf_clr = clr;
        rq2_wptr  = gray(m_wr);
        @(posedge rclk);
        accept = inc && !m_empty;
        m_undf = (inc && m_empty) || (m_undf && !clr);
        if (accept) m_rd++;
        lvl     = m_wr - m_rd;
        m_empty = (lvl == 0);
`ifdef RPTR_LEVEL_EN
        m_level  = lvl;
        m_aempty = (lvl <= AEMPTY_THRESH);
`else
        m_level  = 0;
        m_aempty = m_empty;
`endif
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset asserted between edges while a read is requested.
    task automatic do_reset(input string tag);
        @(negedge rclk);
        rinc = 1'b1;
        #2;
        rrst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        m_wr      = 0;
        rq2_wptr  = '0;
        rinc      = 1'b0;
        rundf_clr = 1'b0;
        @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        m_wr      = 0;
        rrst_n    = 1'b0;
        rinc      = 1'b1;
        rundf_clr = 1'b0;
        rq2_wptr  = 5'b00110;
        model_reset();
        #12;
        check_all("reset");
        rinc     = 1'b0;
        rq2_wptr = '0;
        @(negedge rclk);
        rrst_n = 1'b1;

        // Fill visible then drain
        m_wr = 3;
        step(1'b0, 1'b0, "fill");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "drain");

        // Underflow: set, set-wins-over-clear, clear
        step(1'b1, 1'b0, "undf_set");
        step(1'b0, 1'b0, "undf_hold");
        step(1'b1, 1'b1, "undf_setclr");
        step(1'b0, 1'b1, "undf_clr");

        // Full level from pointer zero
        do_reset("rst_full");
        m_wr = 16;
        step(1'b0, 1'b0, "full");
        step(1'b1, 1'b0, "full_rd");

        // Wrap: one write and one read per cycle across the 31->0 rollover
        do_reset("rst_wrap");
        m_wr = 1;
        step(1'b0, 1'b0, "wrap_pre");
        for (int i = 0; i < 40; i++) begin
            m_wr++;
            step(1'b1, 1'b0, "wrap");
        end

        // Random traffic, level kept within FIFO depth
        for (int i = 0; i < 300; i++) begin
            if ((m_wr - m_rd) < (1 << ADDRSIZE) && $urandom_range(0, 1) == 1) m_wr++;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, "rand");
        end

        // Reset mid-operation with data pending
        m_wr = m_rd + 5;
        step(1'b0, 1'b0, "pre_midrst");
        do_reset("midrst");
        step(1'b0, 1'b0, "post_midrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
